// File: rtl/rect_corner_fetch.sv
// rect_corner_fetch: fetches the four integral-image corners of one Haar
// rectangle from a 1-cycle-latency RAM and streams them in the order BR, TR,
// TL, BL. The weight goes out on its own valid/ready channel.
// Latency: accept at cycle 0 -> mem_en cycles 1-4 -> dout_valid cycles 3-6,
//          sustaining 1 corner/cycle.
// Backpressure: reads stall when the 2-entry output FIFO plus the in-flight
//               read would overflow. dout holds stable while stalled.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   rect_valid/rect_ready          descriptor handshake
//   rect_x/y/w/h, rect_weight      descriptor fields
//   mem_en, mem_addr, mem_data     synchronous RAM read port (data 1 cycle later)
//   dout_valid/ready/data/last     corner stream (last on BL)
//   weight_valid/ready, weight     weight channel
//   err                            sticky bounds error
//
// Optional: define RECT_CORNER_FETCH_BOUNDS_CHECK_EN to flag out-of-range
// rectangles on err and emit four zero words instead of reading the RAM.
module rect_corner_fetch #(
   parameter int IMG_W    = 25,
   parameter int IMG_H    = 25,
   parameter int W_COORD  = 5,
   parameter int W_DATA   = 18,
   parameter int W_WEIGHT = 3,
   parameter int W_ADDR   = $clog2(IMG_W*IMG_H)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rect_valid,
   output logic                       rect_ready,
   input  logic [W_COORD-1:0]         rect_x,
   input  logic [W_COORD-1:0]         rect_y,
   input  logic [W_COORD-1:0]         rect_w,
   input  logic [W_COORD-1:0]         rect_h,
   input  logic signed [W_WEIGHT-1:0] rect_weight,
   output logic                       mem_en,
   output logic [W_ADDR-1:0]          mem_addr,
   input  logic [W_DATA-1:0]          mem_data,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [W_DATA-1:0]          dout_data,
   output logic                       dout_last,
   output logic                       weight_valid,
   input  logic                       weight_ready,
   output logic signed [W_WEIGHT-1:0] weight,
   output logic                       err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [W_ADDR-1:0] LP_IMG_W = W_ADDR'(IMG_W);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [1:0]                 r_idx;
   // Corner addresses in emission order: 0=BR, 1=TR, 2=TL, 3=BL.
   logic [W_ADDR-1:0]          r_addr [4];
   logic                       r_weight_vld;
   logic signed [W_WEIGHT-1:0] r_weight;
   logic                       r_inflight;
   logic                       r_inflight_last;

   logic [W_DATA-1:0]          r_fifo_dat  [2];
   logic                       r_fifo_last [2];
   logic                       r_wr_ptr;
   logic                       r_rd_ptr;
   logic [1:0]                 r_count;

   logic                       w_accept;
   logic                       w_issue;
   logic                       w_push;
   logic                       w_pop;
   logic [1:0]                 w_occ;
   logic                       w_room;
   logic [W_DATA-1:0]          w_push_dat;
   logic [W_ADDR-1:0]          w_x, w_y, w_w, w_h;
   logic [W_ADDR-1:0]          w_tl, w_tr, w_bl, w_br;

   // Address arithmetic is done at W_ADDR width, so out-of-range rectangles
   // wrap rather than saturate.
   assign w_x  = W_ADDR'(rect_x);
   assign w_y  = W_ADDR'(rect_y);
   assign w_w  = W_ADDR'(rect_w);
   assign w_h  = W_ADDR'(rect_h);
   assign w_tl = w_y * LP_IMG_W + w_x;
   assign w_tr = w_tl + w_w;
   assign w_bl = (w_y + w_h) * LP_IMG_W + w_x;
   assign w_br = w_bl + w_w;

   // rect_ready only looks at registered state, so weight_ready never reaches
   // it combinationally.
   assign rect_ready = !rst && (r_state == S_IDLE) && !r_weight_vld;
   assign w_accept   = rect_valid && rect_ready;

   assign dout_valid = (r_count != 2'd0);
   assign w_pop      = dout_valid && dout_ready;
   assign w_push     = r_inflight;
   // Issue only if the word can be guaranteed a FIFO slot when it returns.
   assign w_occ      = r_count + {1'b0, r_inflight};
   assign w_room     = (w_occ - {1'b0, w_pop}) < 2'd2;

`ifdef RECT_CORNER_FETCH_BOUNDS_CHECK_EN
   logic [W_COORD:0] w_xw;
   logic [W_COORD:0] w_yh;
   logic             w_oob;
   logic             r_err;
   logic             r_zero;
   logic             r_inflight_zero;

   assign w_xw  = {1'b0, rect_x} + {1'b0, rect_w};
   assign w_yh  = {1'b0, rect_y} + {1'b0, rect_h};
   assign w_oob = (int'(w_xw) > IMG_W - 1) || (int'(w_yh) > IMG_H - 1);

   // A bad rectangle walks the same issue schedule, but the RAM is left idle
   // and zeros are pushed in place of read data.
   assign mem_en     = w_issue && !r_zero;
   assign w_push_dat = r_inflight_zero ? '0 : mem_data;
   assign err        = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err           <= 1'b0;
         r_zero          <= 1'b0;
         r_inflight_zero <= 1'b0;
      end else begin
         if (w_accept) begin
            r_zero <= w_oob;
            if (w_oob) r_err <= 1'b1;
         end
         r_inflight_zero <= w_issue && r_zero;
      end
   end
`else
   assign mem_en     = w_issue;
   assign w_push_dat = mem_data;
   assign err        = 1'b0;
`endif

   assign mem_addr     = mem_en ? r_addr[r_idx] : '0;
   assign weight_valid = r_weight_vld;
   assign weight       = r_weight;
   assign dout_data    = r_fifo_dat[r_rd_ptr];
   assign dout_last    = r_fifo_last[r_rd_ptr];

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_issue = w_room;
            if (w_room && (r_idx == 2'd3)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_count == 2'd0) && !r_inflight) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_idx           <= 2'd0;
         r_weight_vld    <= 1'b0;
         r_weight        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         for (int i = 0; i < 4; i++) r_addr[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr[0]    <= w_br;
            r_addr[1]    <= w_tr;
            r_addr[2]    <= w_tl;
            r_addr[3]    <= w_bl;
            r_weight     <= rect_weight;
            r_weight_vld <= 1'b1;
            r_idx        <= 2'd0;
         end else begin
            if (weight_ready) r_weight_vld <= 1'b0;
            if (w_issue)      r_idx        <= r_idx + 2'd1;
         end
         // Reset clears this flag, so a word returning after reset is dropped.
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_idx == 2'd3);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_dat[i]  <= '0;
            r_fifo_last[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_fifo_dat[r_wr_ptr]  <= w_push_dat;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: tb/tb_rect_corner_fetch.sv
// Directed bench for rect_corner_fetch. RAM model: mem[a] = 3*a, 1-cycle read.
// Cycle n = period after the n-th posedge following acceptance; inputs are
// driven 1 time unit after the edge and outputs sampled 2 units after it.
module tb_rect_corner_fetch;

   logic              clk = 1'b0;
   logic              rst;
   logic              rect_valid;
   logic              rect_ready;
   logic [4:0]        rect_x, rect_y, rect_w, rect_h;
   logic signed [2:0] rect_weight;
   logic              mem_en;
   logic [9:0]        mem_addr;
   logic [17:0]       mem_data;
   logic              dout_valid;
   logic              dout_ready;
   logic [17:0]       dout_data;
   logic              dout_last;
   logic              weight_valid;
   logic              weight_ready;
   logic signed [2:0] weight;
   logic              err;

   int errors = 0;
   int checks = 0;
   int exp_addr [4];
   int exp_data [4];

   rect_corner_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .rect_valid   (rect_valid),
      .rect_ready   (rect_ready),
      .rect_x       (rect_x),
      .rect_y       (rect_y),
      .rect_w       (rect_w),
      .rect_h       (rect_h),
      .rect_weight  (rect_weight),
      .mem_en       (mem_en),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout_data    (dout_data),
      .dout_last    (dout_last),
      .weight_valid (weight_valid),
      .weight_ready (weight_ready),
      .weight       (weight),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_data <= 18'(3 * mem_addr);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rect(input int x, input int y, input int w, input int h, input int wt);
      rect_x      = 5'(x);
      rect_y      = 5'(y);
      rect_w      = 5'(w);
      rect_h      = 5'(h);
      rect_weight = 3'(wt);
      rect_valid  = 1'b1;
      #1;
      chk("accept_rdy", rect_ready, 1);
   endtask

   // Caller is in cycle 0 with the descriptor driven; checks cycles 1-6.
   task automatic run_stream(input int wexp, input bit zeros, input bit eerr);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         rect_valid = 1'b0;
         dout_ready = 1'b1;
         #1;
         chk("mem_en", mem_en, (!zeros && c <= 4) ? 1 : 0);
         if (!zeros && c <= 4) chk("mem_addr", mem_addr, exp_addr[c-1]);
         chk("dout_valid", dout_valid, (c >= 3) ? 1 : 0);
         if (c >= 3) begin
            chk("dout_data", dout_data, zeros ? 0 : exp_data[c-3]);
            chk("dout_last", dout_last, (c == 6) ? 1 : 0);
         end
         chk("weight_valid", weight_valid, 1);
         chk("weight", weight, wexp);
         chk("err", err, eerr);
      end
   endtask

   // Called in cycle 7 of a stream: pulse weight_ready, then expect the next
   // descriptor to be admitted only in the following cycle.
   task automatic release_weight();
      cyc();
      weight_ready = 1'b1;
      #1;
      chk("rdy_while_wpend", rect_ready, 0);
      chk("wvld_before_pop", weight_valid, 1);
      cyc();
      weight_ready = 1'b0;
      #1;
      chk("rdy_after_wpop", rect_ready, 1);
      chk("wvld_after_pop", weight_valid, 0);
   endtask

   initial begin
      int issued;
      int popped;
      int nout;

      rst          = 1'b1;
      rect_valid   = 1'b0;
      rect_x       = '0;
      rect_y       = '0;
      rect_w       = '0;
      rect_h       = '0;
      rect_weight  = '0;
      dout_ready   = 1'b1;
      weight_ready = 1'b0;
      mem_data     = '0;

      // Reset state
      #3;
      chk("rst_rect_ready", rect_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_weight_valid", weight_valid, 0);
      chk("rst_err", err, 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", rect_ready, 1);
      chk("post_rst_dvalid", dout_valid, 0);

      // Address check, then a back-to-back second rectangle
      exp_addr = '{206, 81, 77, 202};
      exp_data = '{618, 243, 231, 606};
      drive_rect(2, 3, 4, 5, -1);
      run_stream(-1, 1'b0, 1'b0);
      release_weight();

      exp_addr = '{26, 1, 0, 25};
      exp_data = '{78, 3, 0, 75};
      drive_rect(0, 0, 1, 1, 2);
      run_stream(2, 1'b0, 1'b0);
      release_weight();

      // Backpressure: dout_ready low in cycles 3-8
      exp_data = '{618, 243, 231, 606};
      drive_rect(2, 3, 4, 5, -1);
      issued = 0;
      popped = 0;
      nout   = 0;
      for (int c = 1; c <= 20 && nout < 4; c++) begin
         cyc();
         rect_valid = 1'b0;
         dout_ready = (c >= 3 && c <= 8) ? 1'b0 : 1'b1;
         #1;
         if (mem_en) issued++;
         if (dout_valid && dout_ready) popped++;
         chk("bp_outstanding", (issued - popped <= 2) ? 1 : 0, 1);
         if (c >= 3 && c <= 8) begin
            chk("bp_hold_valid", dout_valid, 1);
            chk("bp_hold_data", dout_data, 618);
            chk("bp_hold_last", dout_last, 0);
         end
         if (dout_valid && dout_ready) begin
            chk("bp_data", dout_data, exp_data[nout]);
            chk("bp_last", dout_last, (nout == 3) ? 1 : 0);
            nout++;
         end
      end
      chk("bp_word_count", nout, 4);
      chk("bp_issue_count", issued, 4);
      for (int c = 0; c < 3; c++) cyc();
      weight_ready = 1'b1;
      cyc();
      weight_ready = 1'b0;
      #1;
      chk("bp_idle_ready", rect_ready, 1);

      // Reset mid-operation, asserted asynchronously in cycle 4
      drive_rect(2, 3, 4, 5, -1);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         rect_valid = 1'b0;
      end
      cyc();
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_rect_ready", rect_ready, 0);
      chk("mid_rst_mem_en", mem_en, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_dout_valid", dout_valid, 0);
      chk("mid_rst_dout_data", dout_data, 0);
      chk("mid_rst_dout_last", dout_last, 0);
      chk("mid_rst_weight_valid", weight_valid, 0);
      chk("mid_rst_weight", weight, 0);
      chk("mid_rst_err", err, 0);
      #4;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         #1;
         chk("post_mid_rst_ready", rect_ready, 1);
         chk("post_mid_rst_dvalid", dout_valid, 0);
         chk("post_mid_rst_mem_en", mem_en, 0);
      end

      // Out-of-range rectangle
      drive_rect(20, 0, 6, 1, 1);
`ifdef RECT_CORNER_FETCH_BOUNDS_CHECK_EN
      run_stream(1, 1'b1, 1'b1);
`else
      exp_addr = '{51, 26, 20, 45};
      exp_data = '{153, 78, 60, 135};
      run_stream(1, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
